// File: rtl/step_capture_pkg.sv
// step_capture_pkg: shared motion types and constants for the step capture path.
package step_capture_pkg;
   localparam int W = 32;
   localparam logic [W-1:0] DT_SAT = 32'hFFFF_FFFF;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_STALL = 2'd2} state_t;
   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      return (v == DT_SAT) ? DT_SAT : v + 1'b1;
   endfunction
endpackage

// File: rtl/step_capture_if.sv
// step_capture_if: pin, register-load and feedback signals of step_capture.
interface step_capture_if;
   import step_capture_pkg::*;
   logic         step_in;
   logic         dir_in;
   logic         load;
   logic         set_pos;
   logic         set_timeout;
   logic [W-1:0] pos_val;
   logic [W-1:0] timeout_val;
   logic [W-1:0] position;
   logic [W-1:0] dt;
   logic [W-1:0] last_dt;
   logic         step_stb;
   logic         step_dir;
   logic         timeout_stb;
   logic         stalled;
   modport master (
      output step_in, dir_in, load, set_pos, set_timeout, pos_val, timeout_val,
      input  position, dt, last_dt, step_stb, step_dir, timeout_stb, stalled
   );
   modport slave (
      input  step_in, dir_in, load, set_pos, set_timeout, pos_val, timeout_val,
      output position, dt, last_dt, step_stb, step_dir, timeout_stb, stalled
   );
endinterface

// File: rtl/step_capture_pin_sync_filter.sv
// pin_sync_filter: SYNC_STAGES synchronizer with an optional stability filter
// (STEP_CAPTURE_FILTER_EN); USE_FILTER=0 bypasses the filter for this pin.
module pin_sync_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4,
   parameter bit USE_FILTER  = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_pin,
   output logic o_pin
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_sync;
`ifdef STEP_CAPTURE_FILTER_EN
   localparam bit FILT = USE_FILTER;
`else
   localparam bit FILT = 1'b0 & USE_FILTER;
`endif
   always_ff @(posedge clk) r_sync <= reset ? '0 : {r_sync[SYNC_STAGES-2:0], i_pin};
   assign w_sync = r_sync[SYNC_STAGES-1];
   if (FILT) begin : g_filt
      localparam int CW = $clog2(FILTER_LEN + 1);
      logic [CW-1:0] r_cnt;
      logic          r_out;
      // output only flips after FILTER_LEN consecutive samples disagree with it
      always_ff @(posedge clk) begin
         if (reset) begin
            r_cnt <= '0;
            r_out <= 1'b0;
         end else if (w_sync == r_out) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
            r_cnt <= '0;
            r_out <= w_sync;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
      assign o_pin = r_out;
   end else begin : g_raw
      assign o_pin = w_sync;
   end
endmodule

// File: rtl/step_capture.sv
// step_capture: synchronizes step/dir pins, counts position, measures step
// intervals and flags stalls. Optional input filter: STEP_CAPTURE_FILTER_EN.
module step_capture
   import step_capture_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4,
   parameter bit INVERT_DIR  = 1'b0
) (
   input logic          clk,
   input logic          reset,
   step_capture_if.slave bus
);
`ifdef STEP_CAPTURE_FILTER_EN
   localparam int SETTLE = SYNC_STAGES + FILTER_LEN + 1;
`else
   localparam int SETTLE = SYNC_STAGES + 1;
`endif
   logic         w_step, w_dir, w_eff_dir, w_edge, w_ready;
   logic         r_prev;
   logic [7:0]   r_settle;
   state_t       r_state, w_state_nx;
   logic         w_stb_nx, w_to_nx;
   logic [W-1:0] w_dt_inc, w_dt_nx, w_last_nx;
   logic [W-1:0] r_position, r_dt, r_last_dt, r_limit;
   logic         r_stb, r_dir, r_to;

   pin_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .USE_FILTER(1'b1))
      u_step (.clk(clk), .reset(reset), .i_pin(bus.step_in), .o_pin(w_step));
   pin_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .USE_FILTER(1'b0))
      u_dir (.clk(clk), .reset(reset), .i_pin(bus.dir_in), .o_pin(w_dir));

   // edges are ignored until the pin pipeline has refilled, so a pin already
   // high at reset release is not mistaken for a step
   assign w_ready   = r_settle == 8'(SETTLE);
   assign w_edge    = w_step & ~r_prev & w_ready;
   assign w_eff_dir = w_dir ^ INVERT_DIR;
   assign w_dt_inc  = sat_inc(r_dt);

   always_ff @(posedge clk) begin
      r_prev   <= reset ? 1'b0 : w_step;
      r_settle <= reset ? 8'd0 : (w_ready ? r_settle : r_settle + 8'd1);
   end

   always_ff @(posedge clk) r_state <= reset ? S_IDLE : w_state_nx;

   always_comb begin
      w_state_nx = r_state;
      w_stb_nx   = 1'b0;
      w_to_nx    = 1'b0;
      w_dt_nx    = w_dt_inc;
      w_last_nx  = r_last_dt;
      if (w_edge) begin
         w_state_nx = S_RUN;
         w_stb_nx   = 1'b1;
         w_dt_nx    = '0;
         w_last_nx  = (r_state == S_RUN) ? w_dt_inc : r_last_dt;
      end else if (r_state == S_RUN && r_limit != '0 && w_dt_inc >= r_limit) begin
         w_state_nx = S_STALL;
         w_to_nx    = 1'b1;
      end else if (r_state == S_STALL && bus.load && bus.set_timeout) begin
         w_state_nx = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_position <= '0;
         r_dt       <= '0;
         r_last_dt  <= '0;
         r_limit    <= '0;
         r_stb      <= 1'b0;
         r_dir      <= 1'b0;
         r_to       <= 1'b0;
      end else begin
         r_stb     <= w_stb_nx;
         r_to      <= w_to_nx;
         r_dt      <= w_dt_nx;
         r_last_dt <= w_last_nx;
         if (w_edge) r_dir <= w_eff_dir;
         if (bus.load && bus.set_pos) r_position <= bus.pos_val;
         else if (w_edge) r_position <= w_eff_dir ? r_position + 32'd1 : r_position - 32'd1;
         if (bus.load && bus.set_timeout) r_limit <= bus.timeout_val;
      end
   end

   assign bus.position    = r_position;
   assign bus.dt          = r_dt;
   assign bus.last_dt     = r_last_dt;
   assign bus.step_stb    = r_stb;
   assign bus.step_dir    = r_dir;
   assign bus.timeout_stb = r_to;
   assign bus.stalled     = r_state == S_STALL;
endmodule

// File: tb/tb_step_capture.sv
// tb_step_capture: directed self-checking bench for step_capture.
module tb_step_capture;
   import step_capture_pkg::*;
`ifdef STEP_CAPTURE_FILTER_EN
   localparam int LAT = 7;
`else
   localparam int LAT = 3;
`endif
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   lat, n, c;

   step_capture_if bus();
   step_capture #(.SYNC_STAGES(2), .FILTER_LEN(4), .INVERT_DIR(1'b0))
      dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic load_reg(input logic sp, input logic st, input logic [31:0] v);
      bus.load = 1'b1; bus.set_pos = sp; bus.set_timeout = st;
      bus.pos_val = v; bus.timeout_val = v;
      tick(1);
      bus.load = 1'b0; bus.set_pos = 1'b0; bus.set_timeout = 1'b0;
   endtask

   // raises step_in, returns on the sample where step_stb is seen
   task automatic step_edge(output int l);
      bus.step_in = 1'b1;
      l = 0;
      do begin @(negedge clk); l++; end while (!bus.step_stb && l < 40);
      bus.step_in = 1'b0;
   endtask

   task automatic count_stb(input int k, output int cnt);
      cnt = 0;
      repeat (k) begin @(negedge clk); if (bus.step_stb) cnt++; end
   endtask

   task automatic wait_timeout(output int k);
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.timeout_stb && k < 200);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      bus.step_in = 0; bus.dir_in = 0; bus.load = 0; bus.set_pos = 0;
      bus.set_timeout = 0; bus.pos_val = '0; bus.timeout_val = '0;
      tick(3);
      check("rst_position", bus.position, 0);
      check("rst_dt", bus.dt, 0);
      check("rst_last_dt", bus.last_dt, 0);
      check("rst_stb", bus.step_stb, 0);
      check("rst_dir", bus.step_dir, 0);
      check("rst_to", bus.timeout_stb, 0);
      check("rst_stalled", bus.stalled, 0);
      reset = 1'b0;
      bus.dir_in = 1'b1;
      tick(5);

      // three steps 100 cycles apart
      step_edge(lat);
      check("s1_lat", lat, LAT);
      check("s1_pos", bus.position, 1);
      check("s1_last_dt", bus.last_dt, 0);
      check("s1_dt", bus.dt, 0);
      check("s1_dir", bus.step_dir, 1);
      tick(1);
      check("s1_stb_pulse", bus.step_stb, 0);
      check("s1_dt_next", bus.dt, 1);
      tick(100 - LAT - 1);
      step_edge(lat);
      check("s2_lat", lat, LAT);
      check("s2_last_dt", bus.last_dt, 100);
      tick(100 - LAT);
      step_edge(lat);
      check("s3_lat", lat, LAT);
      check("s3_pos", bus.position, 3);
      check("s3_last_dt", bus.last_dt, 100);

      // timeout / stall
      reset = 1'b1; tick(2); reset = 1'b0; tick(3);
      load_reg(1'b0, 1'b1, 32'd50);
      step_edge(lat);
      tick(30 - LAT);
      step_edge(lat);
      check("t_last_dt", bus.last_dt, 30);
      wait_timeout(n);
      check("t_to_cycle", n, 50);
      check("t_dt_at_to", bus.dt, 50);
      check("t_stalled", bus.stalled, 1);
      tick(1);
      check("t_to_pulse", bus.timeout_stb, 0);
      check("t_stalled_hold", bus.stalled, 1);
      step_edge(lat);
      check("t_unstall", bus.stalled, 0);
      check("t_last_dt_keep", bus.last_dt, 30);
      check("t_dt_zero", bus.dt, 0);
      wait_timeout(n);
      check("t2_to_cycle", n, 50);
      load_reg(1'b0, 1'b1, 32'd0);
      check("t2_stalled_clr", bus.stalled, 0);
      check("t2_to_clr", bus.timeout_stb, 0);
      tick(3);
      step_edge(lat);
      check("t2_idle_last_dt", bus.last_dt, 30);
      check("t2_pos", bus.position, 4);

      // position load and wrap
      tick(3);
      load_reg(1'b1, 1'b0, 32'hFFFF_FFFF);
      check("w_load", bus.position, 32'hFFFF_FFFF);
      bus.load = 1'b1; bus.pos_val = 32'd123; tick(1); bus.load = 1'b0;
      check("w_bare_load", bus.position, 32'hFFFF_FFFF);
      step_edge(lat);
      check("w_wrap_up", bus.position, 0);
      bus.dir_in = 1'b0;
      tick(4);
      step_edge(lat);
      check("w_wrap_dn", bus.position, 32'hFFFF_FFFF);
      check("w_dir0", bus.step_dir, 0);
      tick(3);

      // set_pos coincident with a step
      bus.step_in = 1'b1;
      tick(LAT - 1);
      bus.load = 1'b1; bus.set_pos = 1'b1; bus.pos_val = 32'd10;
      tick(1);
      bus.load = 1'b0; bus.set_pos = 1'b0; bus.step_in = 1'b0;
      check("c_stb", bus.step_stb, 1);
      check("c_pos", bus.position, 10);
      check("c_dt", bus.dt, 0);
      tick(1);
      check("c_pos_hold", bus.position, 10);
      check("c_dt_next", bus.dt, 1);

      // dt saturation
      reset = 1'b1; tick(2); reset = 1'b0; tick(3);
      bus.dir_in = 1'b1;
      step_edge(lat);
      tick(2);
      force dut.r_dt = 32'hFFFF_FFF0;
      tick(1);
      release dut.r_dt;
      tick(30);
      check("sat_dt", bus.dt, DT_SAT);
      step_edge(lat);
      check("sat_last_dt", bus.last_dt, DT_SAT);
      check("sat_dt_clr", bus.dt, 0);

      // step_in high across reset release is not a step
      bus.step_in = 1'b1;
      reset = 1'b1; tick(2); reset = 1'b0;
      count_stb(15, c);
      check("hi_rst_stb", c, 0);
      check("hi_rst_pos", bus.position, 0);
      bus.step_in = 1'b0;
      tick(3);
      step_edge(lat);
      check("hi_rst_real_lat", lat, LAT);
      check("hi_rst_real_pos", bus.position, 1);

`ifdef STEP_CAPTURE_FILTER_EN
      tick(5);
      bus.step_in = 1'b1; tick(2); bus.step_in = 1'b0;
      count_stb(15, c);
      check("f_glitch", c, 0);
      bus.step_in = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; if (n == 6) bus.step_in = 1'b0; end
         while (!bus.step_stb && n < 40);
      check("f_lat", n, 7);
      check("f_pos", bus.position, 2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
